// File: rtl/arbitro_memoria_obstaculos_pkg.sv
// arbitro_memoria_obstaculos_pkg: shared map parameters and arbiter FSM encodings
package arbitro_memoria_obstaculos_pkg;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int NUM_REQ_DEF = 4;
  typedef enum logic {OCIOSO = 1'b0, LIMPANDO = 1'b1} estado_t;
endpackage

// File: rtl/arbitro_memoria_obstaculos_round_robin.sv
// arbitro_round_robin: one-hot round-robin grant, search starts after the last winner
module arbitro_round_robin #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx
);
  logic [PW-1:0] ptr, cand;
  logic [NUM_REQ-1:0] sel;
  logic found;
  always_comb begin
    sel = '0;
    idx = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel[cand] = 1'b1;
        idx = cand;
      end
    end
  end
  // idx reports the candidate even when disabled so the top can run its hazard compare
  assign gnt = enable ? sel : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= PW'(NUM_REQ - 1);
    else if (|gnt) ptr <= idx;
endmodule

// File: rtl/arbitro_memoria_obstaculos.sv
// arbitro_memoria_obstaculos: shares obstacle map RAM ports among readers, a writer and a clear sweep
module arbitro_memoria_obstaculos
  import arbitro_memoria_obstaculos_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            rd_req_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_in,
  output logic [NUM_REQ-1:0]            rd_gnt_out,
  output logic [NUM_REQ-1:0]            rd_valid_out,
  output logic                          rd_data_out,
  input  logic                          wr_req_in,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_in,
  input  logic                          wr_data_in,
  output logic                          wr_ack_out,
  input  logic                          clear_start_in,
  output logic                          busy_out,
  output logic                          mem_rd_enable_out,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr_out,
  input  logic                          mem_rd_data_in,
  output logic                          mem_wr_enable_out,
  output logic [ADDR_WIDTH-1:0]         mem_wr_addr_out,
  output logic                          mem_wr_data_out
);
  estado_t estado, prox;
  logic [ADDR_WIDTH-1:0] contador, rd_addr_sel;
  logic [$clog2(NUM_REQ)-1:0] idx;
  logic ocioso, limpando, risco;
  assign ocioso = rst_n && estado == OCIOSO;
  assign limpando = rst_n && estado == LIMPANDO;
  assign wr_ack_out = ocioso && wr_req_in;
  assign rd_addr_sel = rd_addr_in[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
  // RAM read-during-write returns the old bit, so a colliding read waits one cycle
  assign risco = wr_ack_out && rd_addr_sel == wr_addr_in;
  arbitro_round_robin #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk(clk),
    .rst_n(rst_n),
    .req(rd_req_in),
    .enable(ocioso && !risco),
    .gnt(rd_gnt_out),
    .idx(idx)
  );
  assign mem_rd_enable_out = |rd_gnt_out;
  assign mem_rd_addr_out = mem_rd_enable_out ? rd_addr_sel : '0;
  assign rd_data_out = mem_rd_data_in;
  assign mem_wr_enable_out = wr_ack_out || limpando;
  assign mem_wr_addr_out = limpando ? contador : wr_ack_out ? wr_addr_in : '0;
  assign mem_wr_data_out = wr_ack_out && wr_data_in;
  assign busy_out = estado == LIMPANDO;
  always_comb
    prox = estado == OCIOSO ? (clear_start_in ? LIMPANDO : OCIOSO)
                            : (&contador ? OCIOSO : LIMPANDO);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      estado <= OCIOSO;
      contador <= '0;
      rd_valid_out <= '0;
    end else begin
      estado <= prox;
      contador <= estado == LIMPANDO ? contador + 1'b1 : '0;
      rd_valid_out <= rd_gnt_out;
    end
endmodule

// File: tb/tb_arbitro_memoria_obstaculos.sv
// tb_arbitro_memoria_obstaculos: directed vector table, clear/reset sequences and random traffic against a map model
module tb_arbitro_memoria_obstaculos;
  logic clk, rst_n;
  logic [3:0] rd_req, gnt, valid;
  logic [15:0] rd_addr;
  logic rd_data, wr_req, wr_data, ack, clear_start, busy;
  logic [3:0] wr_addr, m_ra, m_wa;
  logic m_re, m_q, m_we, m_wd;
  logic [15:0] ram, load_val, mdl;
  logic load;
  int pass_cnt = 0, total = 0;

  arbitro_memoria_obstaculos #(.ADDR_WIDTH(4), .NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_in(rd_req), .rd_addr_in(rd_addr), .rd_gnt_out(gnt),
    .rd_valid_out(valid), .rd_data_out(rd_data),
    .wr_req_in(wr_req), .wr_addr_in(wr_addr), .wr_data_in(wr_data), .wr_ack_out(ack),
    .clear_start_in(clear_start), .busy_out(busy),
    .mem_rd_enable_out(m_re), .mem_rd_addr_out(m_ra), .mem_rd_data_in(m_q),
    .mem_wr_enable_out(m_we), .mem_wr_addr_out(m_wa), .mem_wr_data_out(m_wd)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) ram <= load_val;
    else if (m_we) ram[m_wa] <= m_wd;
    if (m_re) m_q <= ram[m_ra];
  end

  typedef struct packed {
    logic [3:0] req; logic wr; logic [3:0] wa; logic wd;
    logic [3:0] gnt; logic ack; logic [3:0] ra; logic [3:0] vld; logic dchk; logic dat;
  } vec_t;
  vec_t tbl [17];

  function automatic vec_t v(input logic [3:0] req, input logic wr, input logic [3:0] wa, input logic wd,
                             input logic [3:0] g, input logic a, input logic [3:0] ra,
                             input logic [3:0] vl, input logic dc, input logic dt);
    return {req, wr, wa, wd, g, a, ra, vl, dc, dt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic e);
    @(negedge clk);
    rd_req = 4'b0001; rd_addr[3:0] = a;
    #1 chk($sformatf("read %0d gnt", a), gnt, 4'b0001);
    @(negedge clk);
    rd_req = 0;
    #1 chk($sformatf("read %0d valid", a), valid, 4'b0001);
    chk($sformatf("read %0d data", a), rd_data, e);
  endtask

  initial begin
    #100000 $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] prev_gnt;
    logic exp_q;
    tbl[0]  = v(4'h1, 0, 0, 0, 4'h1, 0, 5,  4'h0, 0, 0);
    tbl[1]  = v(4'hF, 0, 0, 0, 4'h2, 0, 10, 4'h1, 1, 1);
    tbl[2]  = v(4'hF, 0, 0, 0, 4'h4, 0, 7,  4'h2, 1, 1);
    tbl[3]  = v(4'hF, 0, 0, 0, 4'h8, 0, 12, 4'h4, 1, 0);
    tbl[4]  = v(4'hF, 0, 0, 0, 4'h1, 0, 5,  4'h8, 1, 0);
    tbl[5]  = v(4'hF, 0, 0, 0, 4'h2, 0, 10, 4'h1, 1, 1);
    tbl[6]  = v(4'hF, 0, 0, 0, 4'h4, 0, 7,  4'h2, 1, 1);
    tbl[7]  = v(4'hF, 0, 0, 0, 4'h8, 0, 12, 4'h4, 1, 0);
    tbl[8]  = v(4'hF, 0, 0, 0, 4'h1, 0, 5,  4'h8, 1, 0);
    tbl[9]  = v(4'h0, 1, 7, 1, 4'h0, 1, 0,  4'h1, 1, 1);
    tbl[10] = v(4'h9, 0, 0, 0, 4'h8, 0, 12, 4'h0, 0, 0);
    tbl[11] = v(4'h9, 1, 5, 0, 4'h0, 1, 0,  4'h8, 1, 0);
    tbl[12] = v(4'h9, 0, 0, 0, 4'h1, 0, 5,  4'h0, 0, 0);
    tbl[13] = v(4'h0, 0, 0, 0, 4'h0, 0, 0,  4'h1, 1, 0);
    tbl[14] = v(4'h9, 1, 7, 1, 4'h8, 1, 12, 4'h0, 0, 0);
    tbl[15] = v(4'h4, 0, 0, 0, 4'h4, 0, 7,  4'h8, 1, 0);
    tbl[16] = v(4'h0, 0, 0, 0, 4'h0, 0, 0,  4'h4, 1, 1);
    rst_n = 0; rd_req = 4'hF; rd_addr = 0; wr_req = 1; wr_addr = 0; wr_data = 1;
    clear_start = 0; load = 1; load_val = 16'h0C21;
    @(negedge clk); @(negedge clk);
    #1 chk("reset gnt", gnt, 0);
    chk("reset ack", ack, 0);
    chk("reset rd_en", m_re, 0);
    chk("reset wr_en", m_we, 0);
    chk("reset valid", valid, 0);
    chk("reset busy", busy, 0);
    load = 0; rd_req = 0; wr_req = 0; wr_data = 0;
    @(negedge clk) rst_n = 1;
    rd_addr = {4'd12, 4'd7, 4'd10, 4'd5};
    for (int r = 0; r < 17; r++) begin
      @(negedge clk);
      rd_req = tbl[r].req; wr_req = tbl[r].wr; wr_addr = tbl[r].wa; wr_data = tbl[r].wd;
      #1 chk($sformatf("row%0d gnt", r), gnt, tbl[r].gnt);
      chk($sformatf("row%0d ack", r), ack, tbl[r].ack);
      chk($sformatf("row%0d rd_en", r), m_re, |tbl[r].gnt);
      chk($sformatf("row%0d rd_addr", r), m_ra, tbl[r].ra);
      chk($sformatf("row%0d wr_en", r), m_we, tbl[r].ack);
      chk($sformatf("row%0d valid", r), valid, tbl[r].vld);
      if (tbl[r].dchk) chk($sformatf("row%0d data", r), rd_data, tbl[r].dat);
    end
    // write and read of address 9 collide: read must slip one cycle and see the new bit
    @(negedge clk);
    rd_req = 4'b0001; rd_addr[3:0] = 9; wr_req = 1; wr_addr = 9; wr_data = 1;
    #1 chk("hazard ack", ack, 1);
    chk("hazard gnt withheld", gnt, 0);
    @(negedge clk);
    wr_req = 0;
    #1 chk("hazard retry gnt", gnt, 4'b0001);
    chk("hazard retry addr", m_ra, 9);
    @(negedge clk);
    rd_req = 0;
    #1 chk("hazard valid", valid, 4'b0001);
    chk("hazard data", rd_data, 1);
    // clear sweep, with a read granted in the start cycle
    @(negedge clk);
    clear_start = 1; rd_req = 4'b0001; rd_addr[3:0] = 0;
    #1 chk("clr start gnt", gnt, 4'b0001);
    chk("clr start busy", busy, 0);
    @(negedge clk);
    clear_start = 0; rd_req = 4'hF; wr_req = 1; wr_addr = 3; wr_data = 1;
    #1 chk("clr pending valid", valid, 4'b0001);
    chk("clr pending data", rd_data, 1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk($sformatf("clr%0d busy", k), busy, 1);
      chk($sformatf("clr%0d wr_en", k), m_we, 1);
      chk($sformatf("clr%0d wr_addr", k), m_wa, k);
      chk($sformatf("clr%0d wr_data", k), m_wd, 0);
      chk($sformatf("clr%0d gnt", k), gnt, 0);
      chk($sformatf("clr%0d ack", k), ack, 0);
      chk($sformatf("clr%0d rd_en", k), m_re, 0);
    end
    @(negedge clk);
    rd_req = 0; wr_req = 0;
    #1 chk("clr done busy", busy, 0);
    for (int a = 0; a < 16; a++) rd_chk(4'(a), 0);
    // abort a sweep with reset at address 7
    @(negedge clk) begin load = 1; load_val = 16'hFFFF; end
    @(negedge clk) begin load = 0; clear_start = 1; end
    @(negedge clk) clear_start = 0;
    for (int k = 0; k < 7; k++) @(negedge clk);
    #1 chk("abort at addr", m_wa, 7);
    rst_n = 0;
    #1 chk("abort busy", busy, 0);
    chk("abort wr_en", m_we, 0);
    @(negedge clk) rst_n = 1;
    for (int a = 0; a < 7; a++) rd_chk(4'(a), 0);
    for (int a = 8; a < 16; a++) rd_chk(4'(a), 1);
    @(negedge clk) clear_start = 1;
    @(negedge clk) clear_start = 0;
    #1 n = 0;
    for (int k = 0; k < 40 && busy; k++) begin n++; @(negedge clk); #1; end
    chk("resweep cycles", n, 16);
    rd_chk(8, 0);
    rd_chk(15, 0);
    // random traffic against a map model
    @(negedge clk) begin load = 1; load_val = 16'h3C5A; end
    @(negedge clk) load = 0;
    mdl = 16'h3C5A; prev_gnt = 0; exp_q = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      rd_req = 4'($urandom); rd_addr = 16'($urandom);
      wr_req = $urandom_range(0, 2) == 0; wr_addr = 4'($urandom); wr_data = 1'($urandom);
      #1 chk("rnd ack", ack, wr_req);
      chk("rnd onehot", (gnt & (gnt - 1'b1)) == 0, 1);
      chk("rnd gnt requested", (gnt & ~rd_req) == 0, 1);
      chk("rnd valid", valid, prev_gnt);
      if (prev_gnt != 0) chk("rnd data", rd_data, exp_q);
      if (wr_req) mdl[wr_addr] = wr_data;
      for (int i = 0; i < 4; i++) if (gnt[i]) exp_q = mdl[rd_addr[i*4 +: 4]];
      prev_gnt = gnt;
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
